surf4_spi_wb_bridge: RTL and testbench



---
 rtl/surf4_spi_wb_bridge_pkg.sv | 31 +++
 rtl/surf4_spi_wb_bridge_spi_pin_sync.sv | 52 +++++
 rtl/surf4_spi_wb_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_surf4_spi_wb_bridge.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/surf4_spi_wb_bridge_pkg.sv
// Shared definitions for the SURF4 SPI-to-WISHBONE bridge.
// Holds the frame FSM state encoding, the command bit position, the
// field lengths (in SPI bits) and a helper used to detect field ends.
package surf4_spi_wb_bridge_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CMD   = 4'd1,
        ST_ADDR  = 4'd2,
        ST_WDATA = 4'd3,
        ST_WB_WR = 4'd4,
        ST_WB_RD = 4'd5,
        ST_DUMMY = 4'd6,
        ST_RDATA = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

    localparam int unsigned CMD_WRITE_BIT = 7;
    localparam int unsigned CMD_BITS      = 8;
    localparam int unsigned ADDR_BITS     = 16;
    localparam int unsigned DATA_BITS     = 32;
    localparam int unsigned DUMMY_BITS    = 8;
    localparam int unsigned BIT_CNT_W     = 6;

    // True when the bit counter is on the final bit of a field of length len.
    function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt,
                                         input int unsigned len);
        return (cnt == BIT_CNT_W'(len - 1));
    endfunction

endpackage

// File: rtl/surf4_spi_wb_bridge_spi_pin_sync.sv
// Oversamples the asynchronous SPI pins in clk_i.
// SCK, MOSI and CS_B each pass through two flops; a third flop on SCK and
// CS_B turns level changes into single-cycle edge pulses.
// Ports: clk_i/rst_i system clock and sync reset; spi_*_i raw pins;
//        sck_rise_o/sck_fall_o, cs_rise_o/cs_fall_o edge pulses;
//        mosi_o and cs_b_o synchronised levels.
module surf4_spi_wb_bridge_spi_pin_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_sck_i,
    input  logic spi_mosi_i,
    input  logic spi_cs_b_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic mosi_o,
    output logic cs_b_o,
    output logic cs_rise_o,
    output logic cs_fall_o
);

    logic [2:0] sck_q, sck_d;
    logic [1:0] mosi_q, mosi_d;
    logic [2:0] cs_q, cs_d;

    // Shift each pin one stage further down its synchroniser chain.
    always_comb begin
        sck_d  = {sck_q[1:0], spi_sck_i};
        mosi_d = {mosi_q[0], spi_mosi_i};
        cs_d   = {cs_q[1:0], spi_cs_b_i};
    end

    // Synchroniser flops; CS_B resets to deselected so MISO starts high-Z.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q  <= 3'b000;
            mosi_q <= 2'b00;
            cs_q   <= 3'b111;
        end else begin
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
            cs_q   <= cs_d;
        end
    end

    assign sck_rise_o = sck_q[1] & ~sck_q[2];
    assign sck_fall_o = ~sck_q[1] & sck_q[2];
    assign mosi_o     = mosi_q[1];
    assign cs_b_o     = cs_q[1];
    assign cs_rise_o  = cs_q[1] & ~cs_q[2];
    assign cs_fall_o  = ~cs_q[1] & cs_q[2];

endmodule

// File: rtl/surf4_spi_wb_bridge.sv
// SPI slave (mode 0, MSB first) that issues 32-bit WISHBONE single reads
// and writes on behalf of an external SPI controller.
// Frame: command byte (bit7 = write), 16-bit address, then either 32 write
// data bits, or a dummy byte followed by 32 read data bits on MISO.
// Ports: clk_i/rst_i clock and sync reset; spi_* SPI pins (MISO with
//        tristate control); wb_* WISHBONE initiator; frame_err_o and
//        timeout_o single-cycle error pulses; busy_o FSM not idle.
module surf4_spi_wb_bridge
    import surf4_spi_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_sck_i,
    input  logic        spi_mosi_i,
    input  logic        spi_cs_b_i,
    output logic        spi_miso_o,
    output logic        spi_miso_t_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        frame_err_o,
    output logic        timeout_o,
    output logic        busy_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic sck_rise_s, sck_fall_s, mosi_s, cs_b_s, cs_rise_s, cs_fall_s;

    surf4_spi_wb_bridge_spi_pin_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .spi_sck_i  (spi_sck_i),
        .spi_mosi_i (spi_mosi_i),
        .spi_cs_b_i (spi_cs_b_i),
        .sck_rise_o (sck_rise_s),
        .sck_fall_o (sck_fall_s),
        .mosi_o     (mosi_s),
        .cs_b_o     (cs_b_s),
        .cs_rise_o  (cs_rise_s),
        .cs_fall_o  (cs_fall_s)
    );

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [31:0]            rx_q, rx_d, tx_q, tx_d, dat_q, dat_d;
    logic [31:0]            rx_shift_s;
    logic [15:0]            adr_q, adr_d;
    logic [3:0]             sel_q, sel_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   cmd_wr_q, cmd_wr_d, cyc_q, cyc_d, we_q, we_d;
    logic                   rd_wait_q, rd_wait_d, miso_q, miso_d;
    logic                   frame_err_q, frame_err_d, timeout_q, timeout_d;
    logic                   busy_q, busy_d;

    assign rx_shift_s = {rx_q[30:0], mosi_s};

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= 32'h0;
            tx_q        <= 32'h0;
            dat_q       <= 32'h0;
            adr_q       <= 16'h0;
            sel_q       <= 4'h0;
            to_cnt_q    <= '0;
            cmd_wr_q    <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rd_wait_q   <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            dat_q       <= dat_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            to_cnt_q    <= to_cnt_d;
            cmd_wr_q    <= cmd_wr_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            rd_wait_q   <= rd_wait_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    // Frame FSM next state; a mid-frame deselect abandons the frame.
    always_comb begin
        state_d = state_q;
        if (cs_rise_s && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A pending WISHBONE cycle blocks the start of a new frame.
                    if (cs_fall_s && !cyc_q) state_d = ST_CMD;
                    else                     state_d = ST_IDLE;
                end
                ST_CMD: begin
                    if (sck_rise_s && is_last_bit(bit_cnt_q, CMD_BITS)) state_d = ST_ADDR;
                    else                                                state_d = ST_CMD;
                end
                ST_ADDR: begin
                    if (sck_rise_s && is_last_bit(bit_cnt_q, ADDR_BITS))
                        state_d = cmd_wr_q ? ST_WDATA : ST_WB_RD;
                    else
                        state_d = ST_ADDR;
                end
                ST_WDATA: begin
                    if (sck_rise_s && is_last_bit(bit_cnt_q, DATA_BITS)) state_d = ST_WB_WR;
                    else                                                 state_d = ST_WDATA;
                end
                ST_WB_WR: state_d = ST_DONE;
                ST_WB_RD: state_d = ST_DUMMY;
                ST_DUMMY: begin
                    if (sck_rise_s && is_last_bit(bit_cnt_q, DUMMY_BITS)) state_d = ST_RDATA;
                    else                                                  state_d = ST_DUMMY;
                end
                ST_RDATA: begin
                    if (sck_rise_s && is_last_bit(bit_cnt_q, DATA_BITS)) state_d = ST_DONE;
                    else                                                 state_d = ST_RDATA;
                end
                ST_DONE: begin
                    if (cs_rise_s) state_d = ST_IDLE;
                    else           state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Shift registers, WISHBONE engine, MISO and status outputs.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        dat_d       = dat_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        to_cnt_d    = to_cnt_q;
        cmd_wr_d    = cmd_wr_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        rd_wait_d   = rd_wait_q;
        miso_d      = 1'b0;
        frame_err_d = cs_rise_s && (state_q != ST_IDLE) && (state_q != ST_DONE);
        timeout_d   = 1'b0;
        busy_d      = (state_d != ST_IDLE);

        // Bits are counted per field; the counter restarts on every state change.
        if (state_d != state_q)  bit_cnt_d = '0;
        else if (sck_rise_s)     bit_cnt_d = bit_cnt_q + 1'b1;
        else                     bit_cnt_d = bit_cnt_q;

        if (sck_rise_s && ((state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_WDATA)))
            rx_d = rx_shift_s;
        else
            rx_d = rx_q;

        if ((state_q == ST_CMD) && (state_d == ST_ADDR)) cmd_wr_d = rx_shift_s[CMD_WRITE_BIT];
        else                                              cmd_wr_d = cmd_wr_q;

        if ((state_q == ST_ADDR) && ((state_d == ST_WDATA) || (state_d == ST_WB_RD)))
            adr_d = rx_shift_s[15:0];
        else
            adr_d = adr_q;

        // The cycle runs on its own once issued, so it survives a frame abort.
        if (cyc_q) begin
            if (wb_ack_i) begin
                cyc_d = 1'b0;
                sel_d = 4'h0;
                we_d  = 1'b0;
                if (rd_wait_q) begin
                    tx_d      = wb_dat_i;
                    rd_wait_d = 1'b0;
                end else begin
                    tx_d = tx_q;
                end
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                cyc_d     = 1'b0;
                sel_d     = 4'h0;
                we_d      = 1'b0;
                timeout_d = 1'b1;
                if (rd_wait_q) tx_d = TIMEOUT_DATA;
                else           tx_d = tx_q;
                rd_wait_d = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
            if ((state_q == ST_WDATA) && (state_d == ST_WB_WR)) begin
                cyc_d = 1'b1;
                sel_d = 4'hF;
                we_d  = 1'b1;
                dat_d = rx_shift_s;
            end else if ((state_q == ST_ADDR) && (state_d == ST_WB_RD)) begin
                cyc_d     = 1'b1;
                sel_d     = 4'hF;
                we_d      = 1'b0;
                rd_wait_d = 1'b1;
            end else begin
                cyc_d = 1'b0;
            end
        end

        case (state_q)
            ST_DUMMY: begin
                // Host clocked past the dummy byte before the read acked.
                if ((state_d == ST_RDATA) && rd_wait_q) begin
                    tx_d      = TIMEOUT_DATA;
                    rd_wait_d = 1'b0;
                end else begin
                    rd_wait_d = rd_wait_d;
                end
            end
            ST_RDATA: begin
                if (sck_fall_s) begin
                    miso_d = tx_q[31];
                    tx_d   = {tx_q[30:0], 1'b0};
                end else begin
                    miso_d = miso_q;
                end
            end
            default: miso_d = 1'b0;
        endcase
    end

    assign spi_miso_o   = miso_q;
    assign spi_miso_t_o = cs_b_s;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign frame_err_o  = frame_err_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_surf4_spi_wb_bridge.sv
// Self-checking bench for surf4_spi_wb_bridge: an SPI host task, a
// WISHBONE responder with scoreboard, a table of frames and a few
// hand-written corner-case sequences.
module tb_surf4_spi_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        spi_sck_i, spi_mosi_i, spi_cs_b_i;
    logic        spi_miso_o, spi_miso_t_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [15:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        frame_err_o, timeout_o, busy_o;

    always #5 clk = ~clk;

    surf4_spi_wb_bridge dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .spi_sck_i    (spi_sck_i),
        .spi_mosi_i   (spi_mosi_i),
        .spi_cs_b_i   (spi_cs_b_i),
        .spi_miso_o   (spi_miso_o),
        .spi_miso_t_o (spi_miso_t_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .frame_err_o  (frame_err_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    typedef struct { logic we; logic [15:0] adr; logic [31:0] dat; } wb_exp_t;
    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] adr;
        logic [31:0] dat;      // write data, or responder read data
        int          ack_dly;  // 0 = responder never acks
        logic [31:0] exp_rd;
        int          exp_to;
    } vec_t;

    wb_exp_t     wb_q[$];
    logic [31:0] rd_q[$];
    vec_t        vecs[5];

    int checks = 0, errors = 0;
    int ack_delay = 0, resp_cnt = 0;
    logic [31:0] rd_data = 32'h0;
    int frame_err_cnt = 0, timeout_cnt = 0, cyc_starts = 0, cur_len = 0, last_len = 0;
    logic prev_cyc = 1'b0;
    logic [63:0] cap_r;
    logic tsel_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI mode-0 host: nbits from {cmd, adr, wdat, 8'h0}, MISO sampled before each rise.
    task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] adr,
                             input logic [31:0] wdat, input int nbits, input bit raise);
        logic [63:0] vec;
        vec = {cmd, adr, wdat, 8'h00};
        cap_r = 64'h0;
        spi_cs_b_i = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = vec[63-i];
            repeat (4) @(negedge clk);
            cap_r = {cap_r[62:0], spi_miso_o};
            if (i == 0) tsel_r = spi_miso_t_o;
            spi_sck_i = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck_i = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (raise) begin
            spi_cs_b_i = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic wait_cyc_low(input string name);
        for (int k = 0; k < 500 && wb_cyc_o; k++) @(negedge clk);
        check(name, wb_cyc_o, 1'b0);
    endtask

    // WISHBONE responder, pulse counters and scoreboard comparison at ack.
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (frame_err_o) frame_err_cnt++;
            if (timeout_o)   timeout_cnt++;
            if (wb_cyc_o && !prev_cyc) begin
                cyc_starts++;
                resp_cnt = 0;
                cur_len  = 0;
            end
            if (!wb_cyc_o && prev_cyc) last_len = cur_len;
            if (wb_cyc_o) cur_len++;
            prev_cyc = wb_cyc_o;
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
            end else if (wb_cyc_o && wb_stb_o) begin
                resp_cnt++;
                if (ack_delay > 0 && resp_cnt == ack_delay) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = rd_data;
                    if (wb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected: got cycle adr %0h expected none", wb_adr_o);
                    end else begin
                        wb_exp_t e;
                        e = wb_q.pop_front();
                        check("wb_we", wb_we_o, e.we);
                        check("wb_adr", wb_adr_o, e.adr);
                        check("wb_sel", wb_sel_o, 4'hF);
                        if (e.we) check("wb_dat", wb_dat_o, e.dat);
                    end
                end
            end
        end
    end

    initial begin
        int fe0, to0, st0;
        logic [31:0] exp_w;

        vecs[0] = '{8'h80, 16'h0014, 32'h0000_0001, 2, 32'h0,         0};
        vecs[1] = '{8'h00, 16'h0000, 32'h5334_4137, 3, 32'h5334_4137, 0};
        vecs[2] = '{8'hC3, 16'hABCD, 32'hA5A5_5A5A, 1, 32'h0,         0};
        vecs[3] = '{8'h7F, 16'h1234, 32'h8000_0001, 1, 32'h8000_0001, 0};
        vecs[4] = '{8'h00, 16'h0008, 32'h0,         0, 32'hDEAD_DEAD, 1};

        rst_i = 1'b1;
        spi_sck_i = 1'b0;
        spi_mosi_i = 1'b0;
        spi_cs_b_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        check("rst_adr_dat_sel", {wb_adr_o, wb_dat_o, wb_sel_o}, 52'h0);
        check("rst_miso", {spi_miso_o, spi_miso_t_o}, 2'b01);
        check("rst_pulses_busy", {frame_err_o, timeout_o, busy_o}, 3'b000);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            logic wr;
            wr = vecs[i].cmd[7];
            ack_delay = vecs[i].ack_dly;
            rd_data = vecs[i].dat;
            fe0 = frame_err_cnt; to0 = timeout_cnt; st0 = cyc_starts;
            if (vecs[i].ack_dly > 0) wb_q.push_back('{wr, vecs[i].adr, vecs[i].dat});
            if (!wr) rd_q.push_back(vecs[i].exp_rd);
            spi_frame(vecs[i].cmd, vecs[i].adr, wr ? vecs[i].dat : 32'h0, wr ? 56 : 64, 1'b1);
            wait_cyc_low("cyc_release");
            check("one_wb_cycle", cyc_starts - st0, 1);
            check("timeout_pulses", timeout_cnt - to0, vecs[i].exp_to);
            check("no_frame_err", frame_err_cnt - fe0, 0);
            check("miso_t", {tsel_r, spi_miso_t_o}, 2'b01);
            if (!wr) begin
                exp_w = rd_q.pop_front();
                check("miso_word", cap_r[31:0], exp_w);
                check("miso_dummy", cap_r[39:32], 8'h00);
            end
            if (vecs[i].exp_to != 0) check("timeout_len", last_len, 255);
            repeat (4) @(negedge clk);
        end

        // Write aborted after 20 data bits, then a normal write.
        fe0 = frame_err_cnt; st0 = cyc_starts;
        spi_frame(8'h80, 16'h0040, 32'hFFFF_FFFF, 44, 1'b1);
        check("abort_frame_err", frame_err_cnt - fe0, 1);
        check("abort_no_cycle", cyc_starts - st0, 0);
        ack_delay = 2;
        wb_q.push_back('{1'b1, 16'h0044, 32'h0BAD_CAFE});
        spi_frame(8'h80, 16'h0044, 32'h0BAD_CAFE, 56, 1'b1);
        wait_cyc_low("after_abort_cyc");
        check("after_abort_cycle", cyc_starts - st0, 1);

        // Deselect during an outstanding read; a new select is ignored until it acks.
        fe0 = frame_err_cnt; st0 = cyc_starts;
        ack_delay = 34;
        rd_data = 32'h1111_2222;
        wb_q.push_back('{1'b0, 16'h0100, 32'h0});
        spi_frame(8'h00, 16'h0100, 32'h0, 26, 1'b0);
        spi_cs_b_i = 1'b1;
        repeat (3) @(negedge clk);
        spi_cs_b_i = 1'b0;
        repeat (3) @(negedge clk);
        check("pend_cyc_held", wb_cyc_o, 1'b1);
        check("pend_not_busy", busy_o, 1'b0);
        spi_cs_b_i = 1'b1;
        wait_cyc_low("pend_cyc_done");
        check("pend_frame_err", frame_err_cnt - fe0, 1);
        repeat (10) @(negedge clk);
        ack_delay = 1;
        wb_q.push_back('{1'b1, 16'h0020, 32'hCAFE_F00D});
        spi_frame(8'h80, 16'h0020, 32'hCAFE_F00D, 56, 1'b1);
        wait_cyc_low("post_pend_cyc");
        check("post_pend_cycles", cyc_starts - st0, 2);

        // Reset in the middle of write data.
        st0 = cyc_starts;
        spi_frame(8'h80, 16'h00F0, 32'h1234_5678, 34, 1'b0);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("mid_rst_adr_dat", {wb_adr_o, wb_dat_o, wb_sel_o}, 52'h0);
        check("mid_rst_ctrl", {wb_cyc_o, wb_we_o, busy_o, spi_miso_o, spi_miso_t_o}, 5'b00001);
        spi_cs_b_i = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_write", cyc_starts - st0, 0);

        check("wb_queue_empty", wb_q.size(), 0);
        check("rd_queue_empty", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
